// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard / pipeline-stall controller: same-cycle hazard detection,
// multi-cycle load bubbles, memory-busy freeze, flush arbitration and bubble counting.
module hazard_stall_ctrl #(
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INSTR_W-1:0] instruction_i,
    input  logic               use_rt_i,
    input  logic [ADDR_W-1:0]  ID_EX_RTaddr_i,
    input  logic               ID_EX_MemRead_i,
    input  logic               mem_busy_i,
    input  logic               branch_taken_i,
    input  logic               cnt_clr_i,
    output logic               PC_o,
    output logic               IF_ID_o,
    output logic               Control_mux_o,
    output logic               freeze_o,
    output logic               IF_flush_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam int unsigned REM_W = 4;
    localparam int unsigned RS_LO = 21;
    localparam int unsigned RT_LO = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        LU_HOLD = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [REM_W-1:0]   rem_q;
    logic [REM_W-1:0]   rem_d;
    logic [ADDR_W-1:0]  rs;
    logic [ADDR_W-1:0]  rt;
    logic               lu_hit;
    logic               unused_instr_bits;

    assign rs = instruction_i[RS_LO +: ADDR_W];
    assign rt = instruction_i[RT_LO +: ADDR_W];
    assign unused_instr_bits = ^{instruction_i[INSTR_W-1:RS_LO+ADDR_W],
                                 instruction_i[RT_LO-1:0]};

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign lu_hit = ID_EX_MemRead_i
                  & (ID_EX_RTaddr_i != '0)
                  & ((ID_EX_RTaddr_i == rs) | (use_rt_i & (ID_EX_RTaddr_i == rt)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        PC_o          = 1'b0;
        IF_ID_o       = 1'b0;
        Control_mux_o = 1'b0;
        freeze_o      = 1'b0;
        IF_flush_o    = 1'b0;

        if (mem_busy_i) begin
            // Busy freezes everything and defers any hazard decision.
            freeze_o = 1'b1;
            PC_o     = 1'b1;
            IF_ID_o  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lu_hit) begin
                        PC_o          = 1'b1;
                        IF_ID_o       = 1'b1;
                        Control_mux_o = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LU_HOLD;
                            rem_d   = REM_W'(LOAD_LAT - 1);
                        end
                    end
                end
                LU_HOLD: begin
                    PC_o          = 1'b1;
                    IF_ID_o       = 1'b1;
                    Control_mux_o = 1'b1;
                    rem_d         = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end

        IF_flush_o = branch_taken_i & ~PC_o;

        if (!rst_i) begin
            PC_o          = 1'b0;
            IF_ID_o       = 1'b0;
            Control_mux_o = 1'b0;
            freeze_o      = 1'b0;
            IF_flush_o    = 1'b0;
        end
    end

    // Saturating bubble counter; clear takes priority over increment.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_o <= '0;
        end else if (Control_mux_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three parameterisations driven in lockstep and
// checked against a bubble-budget reference model.
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst_i;
    logic [31:0] instruction;
    logic        use_rt;
    logic [4:0]  ldrt;
    logic        memread;
    logic        busy;
    logic        branch;
    logic        clr;

    logic        pc_o   [3];
    logic        ifid_o [3];
    logic        cm_o   [3];
    logic        fr_o   [3];
    logic        fl_o   [3];
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [3:0]  cnt2;

    int lat  [3] = '{1, 3, 4};
    int cmax [3] = '{65535, 65535, 15};
    int left [3];
    int mcnt [3];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_ctrl #(.INSTR_W(32), .ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk_i(clk), .rst_i(rst_i), .instruction_i(instruction), .use_rt_i(use_rt),
        .ID_EX_RTaddr_i(ldrt), .ID_EX_MemRead_i(memread), .mem_busy_i(busy),
        .branch_taken_i(branch), .cnt_clr_i(clr), .PC_o(pc_o[0]), .IF_ID_o(ifid_o[0]),
        .Control_mux_o(cm_o[0]), .freeze_o(fr_o[0]), .IF_flush_o(fl_o[0]), .stall_cnt_o(cnt0)
    );

    hazard_stall_ctrl #(.INSTR_W(32), .ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
        .clk_i(clk), .rst_i(rst_i), .instruction_i(instruction), .use_rt_i(use_rt),
        .ID_EX_RTaddr_i(ldrt), .ID_EX_MemRead_i(memread), .mem_busy_i(busy),
        .branch_taken_i(branch), .cnt_clr_i(clr), .PC_o(pc_o[1]), .IF_ID_o(ifid_o[1]),
        .Control_mux_o(cm_o[1]), .freeze_o(fr_o[1]), .IF_flush_o(fl_o[1]), .stall_cnt_o(cnt1)
    );

    hazard_stall_ctrl #(.INSTR_W(32), .ADDR_W(5), .LOAD_LAT(4), .CNT_W(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst_i), .instruction_i(instruction), .use_rt_i(use_rt),
        .ID_EX_RTaddr_i(ldrt), .ID_EX_MemRead_i(memread), .mem_busy_i(busy),
        .branch_taken_i(branch), .cnt_clr_i(clr), .PC_o(pc_o[2]), .IF_ID_o(ifid_o[2]),
        .Control_mux_o(cm_o[2]), .freeze_o(fr_o[2]), .IF_flush_o(fl_o[2]), .stall_cnt_o(cnt2)
    );

    task automatic check(input string tag, input int idx, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s[lat=%0d]: observed %0d expected %0d", tag, lat[idx], obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check against the model mid-cycle, then advance.
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] lrt, input logic mr,
                        input logic bz, input logic br, input logic cl);
        logic hit;
        logic stall;
        logic bubble;
        logic [31:0] obs_cnt;
        int nleft [3];
        int ncnt  [3];
        rst_i       = r;
        instruction = {6'($urandom), rs, rt, 16'($urandom)};
        use_rt      = urt;
        ldrt        = lrt;
        memread     = mr;
        busy        = bz;
        branch      = br;
        clr         = cl;
        if (!r) begin
            for (int i = 0; i < 3; i++) begin
                left[i] = 0;
                mcnt[i] = 0;
            end
        end
        #4;
        hit = mr && (lrt != 5'd0) && ((lrt == rs) || (urt && (lrt == rt)));
        for (int i = 0; i < 3; i++) begin
            stall  = r && (bz || left[i] > 0 || hit);
            bubble = r && !bz && (left[i] > 0 || hit);
            obs_cnt = (i == 0) ? 32'(cnt0) : (i == 1) ? 32'(cnt1) : 32'(cnt2);
            check("PC_o",          i, 32'(pc_o[i]),   32'(stall));
            check("IF_ID_o",       i, 32'(ifid_o[i]), 32'(stall));
            check("Control_mux_o", i, 32'(cm_o[i]),   32'(bubble));
            check("freeze_o",      i, 32'(fr_o[i]),   32'(r && bz));
            check("IF_flush_o",    i, 32'(fl_o[i]),   32'(r && br && !stall));
            check("stall_cnt_o",   i, obs_cnt,        32'(mcnt[i]));
            if (!r) begin
                nleft[i] = 0;
                ncnt[i]  = 0;
            end else begin
                if (bz)              nleft[i] = left[i];
                else if (left[i] > 0) nleft[i] = left[i] - 1;
                else if (hit)        nleft[i] = lat[i] - 1;
                else                 nleft[i] = 0;
                if (cl)               ncnt[i] = 0;
                else if (bubble)      ncnt[i] = (mcnt[i] < cmax[i]) ? mcnt[i] + 1 : mcnt[i];
                else                  ncnt[i] = mcnt[i];
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            left[i] = nleft[i];
            mcnt[i] = ncnt[i];
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            left[i] = 0;
            mcnt[i] = 0;
        end
        rst_i = 1'b0; instruction = '0; use_rt = 1'b0; ldrt = '0;
        memread = 1'b0; busy = 1'b0; branch = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, including a branch and a hazard that must stay masked.
        step(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // rs match on rt=5, then the load leaves ID/EX.
        step(1'b1, 5'd5, 5'd9, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);

        // rt match with use_rt, held for one cycle and then removed.
        step(1'b1, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);

        // rt match without use_rt, and register 0: no hazard.
        step(1'b1, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Hazard, busy for two cycles after the first bubble, then the remaining bubbles.
        step(1'b1, 5'd6, 5'd1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd6, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd6, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);

        // Busy together with a hazard: freeze without a bubble, hazard acted on afterwards.
        step(1'b1, 5'd4, 5'd1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd4, 5'd1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Branch with a hazard is suppressed; branch after the stall flushes.
        step(1'b1, 5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd8, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd8, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd8, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd8, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset during the second hold cycle of the four-bubble stall.
        step(1'b1, 5'd9, 5'd1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 5'd9, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd9, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Back-to-back hazards saturate the narrow counter; then clear with a bubble.
        for (int k = 0; k < 20; k++) step(1'b1, 5'd10, 5'd1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd10, 5'd1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(5);

        // Randomized traffic with a small register pool to provoke frequent hits.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
        end
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised load-use hazard and pipeline-stall controller for the five-stage CPU, sitting between IF/ID, ID/EX and the data-memory interface. Detects load-use hazards in the same cycle, as the single-cycle unit does, and keeps stalling for a configurable load latency using an internal counter. Freezes the whole pipeline while data memory is busy, arbitrates branch flushes against stalls, and counts bubble cycles for performance measurement.

## Interface
- INSTR_W, 32: IF/ID instruction width; rs = [25:21], rt = [20:16].
- ADDR_W, 5: register address width.
- LOAD_LAT, 1: bubbles per load-use hazard; legal 1..15.
- CNT_W, 16: width of the bubble counter.

- clk_i  in  1  clock; all registers update on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- instruction_i  in  INSTR_W  instruction currently in IF/ID.
- use_rt_i  in  1  1 = the IF/ID instruction reads rt as a source.
- ID_EX_RTaddr_i  in  ADDR_W  rt (load destination) held in ID/EX.
- ID_EX_MemRead_i  in  1  ID/EX instruction is a load.
- mem_busy_i  in  1  data memory not ready this cycle.
- branch_taken_i  in  1  branch in ID resolved taken.
- cnt_clr_i  in  1  synchronous clear of stall_cnt_o.
- PC_o  out  1  1 = hold PC.
- IF_ID_o  out  1  1 = hold IF/ID.
- Control_mux_o  out  1  1 = zero ID/EX control (insert bubble).
- freeze_o  out  1  1 = hold ID/EX, EX/MEM and MEM/WB.
- IF_flush_o  out  1  1 = flush IF/ID.
- stall_cnt_o  out  CNT_W  count of bubble cycles (saturating).

## Operation
- lu_hit (combinational) = ID_EX_MemRead_i & (ID_EX_RTaddr_i != 0) & ((ID_EX_RTaddr_i == rs) | (use_rt_i & ID_EX_RTaddr_i == rt)). Register 0 never causes a hazard.
- FSM states:
  - IDLE
  - LU_HOLD, with remaining counter rem (4 bits).
- IDLE, mem_busy_i = 0, lu_hit = 1:
  - PC_o = IF_ID_o = Control_mux_o = 1.
  - If LOAD_LAT > 1, go to LU_HOLD with rem = LOAD_LAT-1; otherwise stay in IDLE.
- LU_HOLD, mem_busy_i = 0:
  - PC_o = IF_ID_o = Control_mux_o = 1.
  - rem decrements; return to IDLE in the cycle rem == 1.
  - lu_hit is ignored, because ID/EX holds a bubble.
- mem_busy_i = 1, any state:
  - freeze_o = PC_o = IF_ID_o = 1; Control_mux_o = 0.
  - State and rem hold; lu_hit is not acted on and is re-evaluated once busy drops.
- stall = PC_o. IF_flush_o = branch_taken_i & !stall: a stall suppresses the flush, and the branch re-resolves after the stall.
- stall_cnt_o:
  - Increments by 1 every cycle Control_mux_o = 1 and saturates at all-ones.
  - cnt_clr_i has priority over increment: the next value is 0.
- No output other than stall_cnt_o depends on any register except state.

## Timing
- All control outputs are combinational from the inputs and state in the same cycle: zero-cycle detection latency.
- A load-use hazard produces exactly LOAD_LAT consecutive bubble cycles when mem_busy_i is low. Busy cycles extend that window without consuming bubbles.
- stall_cnt_o updates one edge after the counted cycle.
- While rst_i = 0 (asynchronous):
  - State = IDLE, rem = 0, stall_cnt_o = 0.
  - PC_o, IF_ID_o, Control_mux_o, freeze_o and IF_flush_o are forced to 0.
- Reset asserted mid-LU_HOLD aborts the stall immediately. After release, the unit starts in IDLE.
- Simultaneous mem_busy_i with lu_hit: busy wins, meaning freeze with no bubble.
- Simultaneous branch_taken_i with lu_hit: stall wins and IF_flush_o = 0.
- Simultaneous cnt_clr_i with a bubble: counter becomes 0.

## Test plan
- LOAD_LAT=1: ID/EX load rt=5, IF/ID rs=5 -> one cycle with PC_o=IF_ID_o=Control_mux_o=1, then all 0; stall_cnt_o=1.
- LOAD_LAT=3: hazard on rt=7 with use_rt_i=1 -> three consecutive bubble cycles, then IDLE, stall_cnt_o=3. With use_rt_i=0 and only rt matching -> no stall.
- Load rt=0 matching rs=0 -> no stall, counter unchanged.
- LOAD_LAT=3: mem_busy_i high for 2 cycles after the first bubble -> freeze_o=1, Control_mux_o=0 for those 2 cycles, then 2 more bubbles. Total bubbles 3, total stall cycles 5.
- branch_taken_i=1 together with a hazard -> IF_flush_o=0. branch_taken_i=1 on the cycle after the stall ends -> IF_flush_o=1.
- rst_i pulled low in the 2nd LU_HOLD cycle (LOAD_LAT=4) -> outputs 0 immediately. After release, no stall until a new hazard. Also: force stall_cnt_o to saturate at CNT_W=4 (value 15 holds) and check that cnt_clr_i gives 0.
